bridge_reg_bank: RTL and testbench
==================================

// Module: bridge_reg_bank
// PURPOSE
//  Bridge-side register bank: the endpoint consuming the destination-domain bridge bus produced by the bridge CDC stage.
//  Decodes a word-addressed window and holds NUM_REGS read/write control registers.
//  Exposes NUM_REGS read-only status words and returns read data with fixed pipelined latency.
//  rd_data is held stable between reads, so the CDC return path forwards it only on change.
// PARAMETERS
//  BASE_ADDR   32'hF800_0000  window base; must be 256-byte aligned (bits [7:0] zero)
//  NUM_REGS    8              control regs (1..32); status words share count
//  RD_LATENCY  2              cycles from bridge_rd to rd_data/rd_valid (1..4)
//  MISS_DATA   32'h0000_0000  rd_data returned for any read not hitting a defined word
// PORTS
//  clk             in   1            single clock; all logic on posedge
//  reset_n         in   1            asynchronous assert, active-low reset
//  bridge_addr     in   32           byte address, valid with wr/rd
//  bridge_wr       in   1            one-cycle write pulse
//  bridge_wr_data  in   32           write data, valid with bridge_wr
//  bridge_rd       in   1            one-cycle read pulse
//  bridge_rd_data  out  32           read data, held until next read completes
//  rd_valid        out  1            one-cycle pulse when bridge_rd_data updated
//  ctrl_regs       out  NUM_REGS*32  control reg i at [32*i+:32]
//  ctrl_wr_strobe  out  NUM_REGS     bit i pulses the cycle after ctrl reg i is written
//  status_in       in   NUM_REGS*32  status word i at [32*i+:32], already in clk domain
// BEHAVIOUR
//  Reset (reset_n=0, async): ctrl_regs=0, ctrl_wr_strobe=0, bridge_rd_data=0, rd_valid=0, read pipe flushed.
//  Decode: hit = addr[31:8]==BASE_ADDR[31:8]; word w = addr[7:2]; addr[1:0] ignored.
//   w in [0, NUM_REGS): ctrl reg w (RW).
//   w in [NUM_REGS, 2*NUM_REGS): status word w-NUM_REGS (RO).
//   Anything else, or no hit: miss.
//  Write: bridge_wr to ctrl word w -> ctrl_regs[w] = wr_data on the next edge; strobe bit w high one cycle, same edge.
//   Writes to status words or misses: no effect, no strobe.
//  Read: bridge_rd captures address, decodes, and samples the selected value into a RD_LATENCY-deep pipe.
//   Stage 0 samples in the bridge_rd cycle; rd_data and rd_valid update RD_LATENCY edges after the bridge_rd edge.
//   Ctrl reads return the register value before any same-cycle write.
//   Status reads return status_in sampled in the bridge_rd cycle; misses return MISS_DATA.
//  Back-to-back: one read per cycle accepted; results return in order; each read produces exactly one rd_valid.
//  Simultaneous wr and rd, same cycle: both processed; the read sees the old value; the write takes effect normally.
//  rd_data holds its value indefinitely when no read completes; never changes without rd_valid.
//  Reset mid-read: pipe flushed, no rd_valid emitted after reset release for pre-reset reads.
//  No backpressure; bridge_wr/bridge_rd are never ignored.
// CONFIGURATION
//  BRIDGE_REG_BANK_W1C_EN defined: each status word is sticky.
//   sticky[i] |= status_in[i] every cycle; reads return the sticky value.
//   Writing a status word clears the bits set in wr_data (write-1-to-clear).
//   Clear and a new set of the same bit in the same cycle -> bit stays 1.
//   Reset clears all sticky bits.
//  Not defined: status reads return live status_in; status-word writes ignored; no sticky storage.
// TESTING
//  1 Reset -> ctrl_regs=0, bridge_rd_data=0, rd_valid=0, strobes=0; assert reset_n low mid-read -> no stray rd_valid.
//  2 wr 0xF800_0004 data 0x1234_5678 -> ctrl_regs[63:32]=0x12345678, ctrl_wr_strobe=8'b0000_0010 for 1 cycle.
//  3 rd 0xF800_0004 -> after RD_LATENCY=2 cycles rd_data=0x12345678, rd_valid 1 cycle; data holds thereafter.
//  4 status_in[0]=0xA5 + rd 0xF800_0020 -> 0xA5.
//    rd 0xF800_0040 / 0x1000_0000 -> MISS_DATA; wr to status word -> no ctrl change.
//  5 Back-to-back rd words 0,1,8 with same-cycle wr word 0 -> three in-order rd_valid; word 0 returns old value.
//  6 W1C_EN: status_in[0] pulses 0x3 then 0 -> read 0x3.
//    wr 0x1 to word 8 -> read 0x2; with status_in[0]=0x1 held during clear -> read 0x3.

Source files
------------

// File: rtl/bridge_reg_bank.sv
// bridge_reg_bank: destination-domain endpoint of the bridge bus.
// Decodes a 256-byte word-addressed window at BASE_ADDR into NUM_REGS
// read/write control registers followed by NUM_REGS read-only status words.
// Reads return through a RD_LATENCY-deep pipe. The read data output only
// changes on rd_valid, so the return path can forward it on change.
// Optional feature: define BRIDGE_REG_BANK_W1C_EN to make every status word
// sticky (OR-accumulated) and clearable by write-1-to-clear.
module bridge_reg_bank #(
  parameter logic [31:0] BASE_ADDR  = 32'hF800_0000,
  parameter int          NUM_REGS   = 8,
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] MISS_DATA  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              bridge_addr,
  input  logic                     bridge_wr,
  input  logic [31:0]              bridge_wr_data,
  input  logic                     bridge_rd,
  output logic [31:0]              bridge_rd_data,
  output logic                     rd_valid,
  output logic [NUM_REGS*32-1:0]   ctrl_regs,
  output logic [NUM_REGS-1:0]      ctrl_wr_strobe,
  input  logic [NUM_REGS*32-1:0]   status_in
);

  logic                   hit;
  logic [6:0]             word;
  logic                   unused_addr_bits;
  logic [NUM_REGS-1:0]    wr_sel;
  logic [31:0]            rd_value;
  logic [NUM_REGS*32-1:0] status_view;
  logic [RD_LATENCY-1:0]  vld_p;

  // Window hit on the upper 24 address bits; byte offset within a word ignored.
  assign hit              = (bridge_addr[31:8] == BASE_ADDR[31:8]);
  assign word             = {1'b0, bridge_addr[7:2]};
  assign unused_addr_bits = ^bridge_addr[1:0];

`ifdef BRIDGE_REG_BANK_W1C_EN
  logic [NUM_REGS*32-1:0] sticky;
  logic [NUM_REGS-1:0]    clr_sel;

  assign status_view = sticky;

  // Select which sticky status word a write targets.
  always_comb begin
    clr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      clr_sel[i] = bridge_wr && hit && (word == 7'(NUM_REGS + i));
  end

  // Sticky accumulate; a new set wins over a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        sticky[32*i +: 32] <= (sticky[32*i +: 32] & ~(clr_sel[i] ? bridge_wr_data : 32'h0))
                              | status_in[32*i +: 32];
    end
  end
`else
  assign status_view = status_in;
`endif

  // Decode write target among control words and pick read source.
  always_comb begin
    wr_sel   = '0;
    rd_value = MISS_DATA;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = bridge_wr && hit && (word == 7'(i));
      if (hit && (word == 7'(i)))
        rd_value = ctrl_regs[32*i +: 32];
      if (hit && (word == 7'(NUM_REGS + i)))
        rd_value = status_view[32*i +: 32];
    end
  end

  // Control register writes and their one-cycle strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_regs      <= '0;
      ctrl_wr_strobe <= '0;
    end else begin
      ctrl_wr_strobe <= wr_sel;
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_sel[i])
          ctrl_regs[32*i +: 32] <= bridge_wr_data;
    end
  end

  // Read valid shift register; reset flushes all in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      vld_p <= '0;
    else
      vld_p <= RD_LATENCY'({vld_p, bridge_rd});
  end

  for (genvar k = 0; k < RD_LATENCY; k++) begin : g_pipe
    logic [31:0] d_in;
    logic [31:0] data;
    logic        v_in;

    if (k == 0) begin : g_head
      assign d_in = rd_value;
      assign v_in = bridge_rd;
    end else begin : g_body
      assign d_in = g_pipe[k-1].data;
      assign v_in = vld_p[k-1];
    end

    if (k == RD_LATENCY - 1) begin : g_out
      // Output stage: loads only on a completing read, otherwise holds.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          data <= '0;
        else if (v_in)
          data <= d_in;
      end
    end else begin : g_mid
      // Intermediate stage: data only, qualified by the travelling valid.
      always_ff @(posedge clk) begin
        if (v_in)
          data <= d_in;
      end
    end
  end

  assign bridge_rd_data = g_pipe[RD_LATENCY-1].data;
  assign rd_valid       = vld_p[RD_LATENCY-1];

endmodule

// File: tb/tb_bridge_reg_bank.sv
// Testbench for bridge_reg_bank: scoreboard of expected read returns with
// their due cycle, consumed by a monitor whenever rd_valid is seen.
// Sticky-status scenario is built only when BRIDGE_REG_BANK_W1C_EN is defined.
module tb_bridge_reg_bank;
  localparam int          NR   = 8;
  localparam int          LAT  = 2;
  localparam logic [31:0] MISS = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [31:0]       bridge_addr = '0;
  logic              bridge_wr = 1'b0;
  logic [31:0]       bridge_wr_data = '0;
  logic              bridge_rd = 1'b0;
  logic [31:0]       bridge_rd_data;
  logic              rd_valid;
  logic [NR*32-1:0]  ctrl_regs;
  logic [NR-1:0]     ctrl_wr_strobe;
  logic [NR*32-1:0]  status_in = '0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          vld_count = 0;
  logic [31:0] held = '0;
  logic [31:0] model_ctrl [NR];

  bridge_reg_bank #(
    .BASE_ADDR (32'hF800_0000),
    .NUM_REGS  (NR),
    .RD_LATENCY(LAT),
    .MISS_DATA (MISS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bridge_addr   (bridge_addr),
    .bridge_wr     (bridge_wr),
    .bridge_wr_data(bridge_wr_data),
    .bridge_rd     (bridge_rd),
    .bridge_rd_data(bridge_rd_data),
    .rd_valid      (rd_valid),
    .ctrl_regs     (ctrl_regs),
    .ctrl_wr_strobe(ctrl_wr_strobe),
    .status_in     (status_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle; a read pushes its expected return and due cycle.
  task automatic drive(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd);
    bridge_wr      = wr;
    bridge_rd      = rd;
    bridge_addr    = addr;
    bridge_wr_data = data;
    if (rd) sb.push_back('{data: exp_rd, due: cyc + LAT});
    step();
    bridge_wr = 1'b0;
    bridge_rd = 1'b0;
  endtask

  // Pops the scoreboard on every rd_valid; checks data holds otherwise.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held = '0;
      end else if (rd_valid) begin
        vld_count++;
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL stray_rd_valid got rd_data=%h with no read outstanding at cycle %0d",
                   bridge_rd_data, cyc);
        end else begin
          e = sb.pop_front();
          if (bridge_rd_data !== e.data || cyc !== e.due)
            $display("FAIL rd_return got data=%h cycle=%0d expected data=%h cycle=%0d",
                     bridge_rd_data, cyc, e.data, e.due);
          else
            pass_cnt++;
        end
        held = bridge_rd_data;
      end else begin
        chk_cnt++;
        if (bridge_rd_data !== held)
          $display("FAIL rd_data_hold got %h expected %h at cycle %0d", bridge_rd_data, held, cyc);
        else
          pass_cnt++;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk_cnt++;
    if (sb.size() != 0) begin
      $display("FAIL drain_timeout got %0d reads outstanding expected 0", sb.size());
      sb.delete();
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    chk_cnt++;
    if (ctrl_regs !== '0) $display("FAIL reset_ctrl got %h expected 0", ctrl_regs);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_wr_strobe !== '0) $display("FAIL reset_strobe got %b expected 0", ctrl_wr_strobe);
    else pass_cnt++;
    chk_cnt++;
    if (bridge_rd_data !== '0) $display("FAIL reset_rd_data got %h expected 0", bridge_rd_data);
    else pass_cnt++;
    chk_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b expected 0", rd_valid);
    else pass_cnt++;
    for (int i = 0; i < NR; i++) model_ctrl[i] = '0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_ctrl_write();
    drive(1'b1, 1'b0, 32'hF800_0004, 32'h1234_5678, '0);
    model_ctrl[1] = 32'h1234_5678;
    chk_cnt++;
    if (ctrl_regs[63:32] !== 32'h1234_5678) $display("FAIL wr_word1 got %h expected 12345678", ctrl_regs[63:32]);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_wr_strobe !== 8'b0000_0010) $display("FAIL wr_strobe1 got %b expected 00000010", ctrl_wr_strobe);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (ctrl_wr_strobe !== 8'b0) $display("FAIL wr_strobe_clear got %b expected 0", ctrl_wr_strobe);
    else pass_cnt++;
    // Last control word, with nonzero byte offset bits.
    drive(1'b1, 1'b0, 32'hF800_001F, 32'h7777_0007, '0);
    model_ctrl[7] = 32'h7777_0007;
    chk_cnt++;
    if (ctrl_regs[255:224] !== 32'h7777_0007) $display("FAIL wr_word7 got %h expected 77770007", ctrl_regs[255:224]);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_wr_strobe !== 8'b1000_0000) $display("FAIL wr_strobe7 got %b expected 10000000", ctrl_wr_strobe);
    else pass_cnt++;
  endtask

  task automatic test_ctrl_read();
    drive(1'b0, 1'b1, 32'hF800_0004, '0, model_ctrl[1]);
    drain();
    repeat (3) step();
    chk_cnt++;
    if (bridge_rd_data !== 32'h1234_5678) $display("FAIL rd_hold got %h expected 12345678", bridge_rd_data);
    else pass_cnt++;
    drive(1'b0, 1'b1, 32'hF800_001C, '0, model_ctrl[7]);
    drain();
  endtask

  task automatic test_status_miss();
    logic [NR*32-1:0] snap;
    status_in[31:0]    = 32'h0000_00A5;
    status_in[255:224] = 32'h5A5A_0077;
    step();
    drive(1'b0, 1'b1, 32'hF800_0020, '0, 32'h0000_00A5);
    drive(1'b0, 1'b1, 32'hF800_003C, '0, 32'h5A5A_0077);
    drive(1'b0, 1'b1, 32'hF800_0040, '0, MISS);
    drive(1'b0, 1'b1, 32'h1000_0000, '0, MISS);
    drive(1'b0, 1'b1, 32'h1000_0004, '0, MISS);
    drain();
    snap = ctrl_regs;
    drive(1'b1, 1'b0, 32'hF800_0020, 32'hFFFF_FFFF, '0);
    chk_cnt++;
    if (ctrl_regs !== snap || ctrl_wr_strobe !== '0)
      $display("FAIL status_wr got ctrl=%h strobe=%b expected ctrl=%h strobe=0", ctrl_regs, ctrl_wr_strobe, snap);
    else pass_cnt++;
    drive(1'b1, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, '0);
    chk_cnt++;
    if (ctrl_regs !== snap || ctrl_wr_strobe !== '0)
      $display("FAIL miss_wr got ctrl=%h strobe=%b expected ctrl=%h strobe=0", ctrl_regs, ctrl_wr_strobe, snap);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int v0;
    drive(1'b1, 1'b0, 32'hF800_0000, 32'h1111_0000, '0);
    model_ctrl[0] = 32'h1111_0000;
    v0 = vld_count;
    drive(1'b1, 1'b1, 32'hF800_0000, 32'hBEEF_0000, model_ctrl[0]);
    model_ctrl[0] = 32'hBEEF_0000;
    drive(1'b0, 1'b1, 32'hF800_0004, '0, model_ctrl[1]);
    drive(1'b0, 1'b1, 32'hF800_0020, '0, 32'h0000_00A5);
    drain();
    chk_cnt++;
    if (vld_count - v0 !== 3) $display("FAIL b2b_count got %0d expected 3", vld_count - v0);
    else pass_cnt++;
    chk_cnt++;
    if (ctrl_regs[31:0] !== 32'hBEEF_0000) $display("FAIL b2b_wr got %h expected beef0000", ctrl_regs[31:0]);
    else pass_cnt++;
    drive(1'b0, 1'b1, 32'hF800_0000, '0, model_ctrl[0]);
    drain();
  endtask

  task automatic test_reset_mid_read();
    int v0;
    drive(1'b0, 1'b1, 32'hF800_0004, '0, 32'h0);
    reset_n = 1'b0;
    sb.delete();
    v0 = vld_count;
    step();
    step();
    chk_cnt++;
    if (ctrl_regs !== '0 || bridge_rd_data !== '0)
      $display("FAIL midrd_reset got ctrl=%h rd=%h expected 0", ctrl_regs, bridge_rd_data);
    else pass_cnt++;
    for (int i = 0; i < NR; i++) model_ctrl[i] = '0;
    reset_n = 1'b1;
    repeat (5) step();
    chk_cnt++;
    if (vld_count !== v0) $display("FAIL midrd_stray got %0d rd_valid expected 0", vld_count - v0);
    else pass_cnt++;
  endtask

`ifdef BRIDGE_REG_BANK_W1C_EN
  task automatic test_w1c();
    status_in = '0;
    step();
    drive(1'b1, 1'b0, 32'hF800_0020, 32'hFFFF_FFFF, '0);
    status_in[31:0] = 32'h3;
    step();
    status_in[31:0] = 32'h0;
    step();
    drive(1'b0, 1'b1, 32'hF800_0020, '0, 32'h3);
    drain();
    drive(1'b1, 1'b0, 32'hF800_0020, 32'h1, '0);
    drive(1'b0, 1'b1, 32'hF800_0020, '0, 32'h2);
    drain();
    status_in[31:0] = 32'h1;
    drive(1'b1, 1'b0, 32'hF800_0020, 32'h1, '0);
    drive(1'b0, 1'b1, 32'hF800_0020, '0, 32'h3);
    drain();
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_ctrl_write();
    test_ctrl_read();
    test_status_miss();
    test_back_to_back();
    test_reset_mid_read();
`ifdef BRIDGE_REG_BANK_W1C_EN
    test_w1c();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
